// File: rtl/player_motion_ctrl.sv
// -----------------------------------------------------------------------------
// player_motion_ctrl
// Per-frame player movement, facing direction and shot timing driven by a
// rollover keyboard report. All game state advances only on the rising edge
// of the frame sync (one "tick" per frame).
//
// Ports
//   Clk      in   system clock, all state on rising edge
//   Reset_n  in   asynchronous active-low reset
//   VGA_VS   in   frame sync level, synchronous to Clk
//   keycode  in   NKEYS 8-bit key slots, slot i at [8i+7:8i]
//   x, y     out  registered player position, clamped to the map bounds
//   dir      out  registered facing: 0=N 1=S 2=E 3=W
//   fire     out  one-Clk shot pulse
//   moving   out  registered, 1 when the position changed on the last frame
// -----------------------------------------------------------------------------
module player_motion_ctrl #(
   parameter int         NKEYS    = 4,
   parameter int         W        = 12,
   parameter int         STEP     = 2,
   parameter int         X_MIN    = 64,
   parameter int         X_MAX    = 3136,
   parameter int         Y_MIN    = 64,
   parameter int         Y_MAX    = 2336,
   parameter int         X_INIT   = 700,
   parameter int         Y_INIT   = 700,
   parameter logic [7:0] KEY_UP   = 8'h1A,
   parameter logic [7:0] KEY_DN   = 8'h16,
   parameter logic [7:0] KEY_LT   = 8'h04,
   parameter logic [7:0] KEY_RT   = 8'h07,
   parameter logic [7:0] KEY_AUP  = 8'h52,
   parameter logic [7:0] KEY_ADN  = 8'h51,
   parameter logic [7:0] KEY_ALT  = 8'h50,
   parameter logic [7:0] KEY_ART  = 8'h4F,
   parameter logic [7:0] KEY_FIRE = 8'h2C,
   parameter int         COOLDOWN = 30
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 VGA_VS,
   input  logic [8*NKEYS-1:0]   keycode,
   output logic [W-1:0]         x,
   output logic [W-1:0]         y,
   output logic [1:0]           dir,
   output logic                 fire,
   output logic                 moving
);

   localparam logic [0:0] S_READY = 1'b0;
   localparam logic [0:0] S_COOL  = 1'b1;

   localparam logic signed [W+1:0] STEP_S = STEP[W+1:0];
   localparam logic signed [W+1:0] XMIN_S = X_MIN[W+1:0];
   localparam logic signed [W+1:0] XMAX_S = X_MAX[W+1:0];
   localparam logic signed [W+1:0] YMIN_S = Y_MIN[W+1:0];
   localparam logic signed [W+1:0] YMAX_S = Y_MAX[W+1:0];
   localparam logic [W-1:0]        XINIT  = X_INIT[W-1:0];
   localparam logic [W-1:0]        YINIT  = Y_INIT[W-1:0];
   localparam logic [7:0]          CD     = COOLDOWN[7:0];

   // A key is pressed if any slot holds it; 8'h00 marks an empty slot.
   function automatic logic key_hit(input logic [8*NKEYS-1:0] kc,
                                    input logic [7:0]         k);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NKEYS; i++) begin
         if ((kc[8*i +: 8] == k) && (k != 8'h00)) hit = 1'b1;
      end
      return hit;
   endfunction

   // Opposing keys cancel; a single key gives +/-STEP.
   function automatic logic signed [W+1:0] axis_delta(input logic pos,
                                                      input logic neg);
      logic signed [W+1:0] d;
      d = '0;
      if (pos && !neg)      d = STEP_S;
      else if (neg && !pos) d = -STEP_S;
      return d;
   endfunction

   function automatic logic [W-1:0] clamp(input logic signed [W+1:0] v,
                                          input logic signed [W+1:0] lo,
                                          input logic signed [W+1:0] hi);
      logic signed [W+1:0] c;
      c = v;
      if (v < lo)      c = lo;
      else if (v > hi) c = hi;
      return c[W-1:0];
   endfunction

   logic          r_vs_d;
   logic [0:0]    r_state;
   logic [7:0]    r_cnt;
   logic [W-1:0]  r_x;
   logic [W-1:0]  r_y;
   logic [1:0]    r_dir;
   logic          r_fire;
   logic          r_moving;

   logic          w_tick;
   logic          w_up, w_dn, w_lt, w_rt;
   logic          w_aup, w_adn, w_alt, w_art, w_fire_key;
   logic [W-1:0]  w_nx, w_ny;
   logic [1:0]    w_ndir;
   logic [7:0]    w_cnt_dec;

   assign w_tick     = VGA_VS & ~r_vs_d;

   assign w_up       = key_hit(keycode, KEY_UP);
   assign w_dn       = key_hit(keycode, KEY_DN);
   assign w_lt       = key_hit(keycode, KEY_LT);
   assign w_rt       = key_hit(keycode, KEY_RT);
   assign w_aup      = key_hit(keycode, KEY_AUP);
   assign w_adn      = key_hit(keycode, KEY_ADN);
   assign w_alt      = key_hit(keycode, KEY_ALT);
   assign w_art      = key_hit(keycode, KEY_ART);
   assign w_fire_key = key_hit(keycode, KEY_FIRE);

   // Each axis is clamped on its own so hitting one wall still lets the
   // player slide along it.
   assign w_nx = clamp($signed({2'b00, r_x}) + axis_delta(w_rt, w_lt), XMIN_S, XMAX_S);
   assign w_ny = clamp($signed({2'b00, r_y}) + axis_delta(w_dn, w_up), YMIN_S, YMAX_S);

   // Aim keys override movement keys for facing; no key held keeps facing.
   always_comb begin
      w_ndir = r_dir;
      if      (w_art) w_ndir = 2'd2;
      else if (w_alt) w_ndir = 2'd3;
      else if (w_adn) w_ndir = 2'd1;
      else if (w_aup) w_ndir = 2'd0;
      else if (w_rt)  w_ndir = 2'd2;
      else if (w_lt)  w_ndir = 2'd3;
      else if (w_dn)  w_ndir = 2'd1;
      else if (w_up)  w_ndir = 2'd0;
   end

   assign w_cnt_dec = r_cnt - 8'd1;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         // vs_d starts high so a sync already high at release is not a tick.
         r_vs_d   <= 1'b1;
         r_state  <= S_READY;
         r_cnt    <= 8'd0;
         r_x      <= XINIT;
         r_y      <= YINIT;
         r_dir    <= 2'd0;
         r_fire   <= 1'b0;
         r_moving <= 1'b0;
      end else begin
         r_vs_d <= VGA_VS;
         r_fire <= 1'b0;
         if (w_tick) begin
            r_x      <= w_nx;
            r_y      <= w_ny;
            r_dir    <= w_ndir;
            r_moving <= (w_nx != r_x) || (w_ny != r_y);
            case (r_state)
               S_READY: begin
                  if (w_fire_key) begin
                     r_fire  <= 1'b1;
                     r_cnt   <= CD;
                     r_state <= S_COOL;
                  end
               end
               default: begin
                  // The tick that empties the counter only re-arms; the next
                  // tick can fire, giving a COOLDOWN+1 frame repeat period.
                  r_cnt <= w_cnt_dec;
                  if (w_cnt_dec == 8'd0) r_state <= S_READY;
               end
            endcase
         end
      end
   end

   assign x      = r_x;
   assign y      = r_y;
   assign dir    = r_dir;
   assign fire   = r_fire;
   assign moving = r_moving;

endmodule

// File: tb/tb_player_motion_ctrl.sv
module tb_player_motion_ctrl;

   localparam logic [7:0] K_UP   = 8'h1A;
   localparam logic [7:0] K_DN   = 8'h16;
   localparam logic [7:0] K_LT   = 8'h04;
   localparam logic [7:0] K_RT   = 8'h07;
   localparam logic [7:0] K_ART  = 8'h4F;
   localparam logic [7:0] K_FIRE = 8'h2C;

   logic        clk;
   logic        Reset_n;
   logic        VGA_VS;
   logic [31:0] keycode;

   logic [11:0] x1, y1, x2, y2;
   logic [1:0]  dir1, dir2;
   logic        fire1, fire2, mov1, mov2;

   int total = 0;
   int bad   = 0;

   player_motion_ctrl u_dut1 (
      .Clk(clk), .Reset_n(Reset_n), .VGA_VS(VGA_VS), .keycode(keycode),
      .x(x1), .y(y1), .dir(dir1), .fire(fire1), .moving(mov1)
   );

   player_motion_ctrl #(.COOLDOWN(3), .X_INIT(3135)) u_dut2 (
      .Clk(clk), .Reset_n(Reset_n), .VGA_VS(VGA_VS), .keycode(keycode),
      .x(x2), .y(y2), .dir(dir2), .fire(fire2), .moving(mov2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset();
      Reset_n = 1'b0;
      VGA_VS  = 1'b0;
      keycode = '0;
      repeat (2) @(negedge clk);
      Reset_n = 1'b1;
      @(negedge clk);
   endtask

   // One frame: f = fire right after the tick edge, g = fire one Clk later.
   task automatic do_tick(output logic f1, output logic f2,
                          output logic g1, output logic g2);
      @(negedge clk);
      VGA_VS = 1'b1;
      @(negedge clk);
      f1 = fire1; f2 = fire2;
      @(negedge clk);
      g1 = fire1; g2 = fire2;
      VGA_VS = 1'b0;
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      logic a, b, c, d;
      for (int i = 0; i < n; i++) do_tick(a, b, c, d);
   endtask

   task automatic test_reset();
      #3 Reset_n = 1'b0;
      VGA_VS  = 1'b0;
      keycode = '0;
      #1;
      total++; if (x1 !== 12'd700) begin bad++; $display("FAIL reset_x got=%0d exp=700", x1); end
      total++; if (y1 !== 12'd700) begin bad++; $display("FAIL reset_y got=%0d exp=700", y1); end
      total++; if (dir1 !== 2'd0) begin bad++; $display("FAIL reset_dir got=%0d exp=0", dir1); end
      total++; if (mov1 !== 1'b0) begin bad++; $display("FAIL reset_moving got=%0b exp=0", mov1); end
      total++; if (fire1 !== 1'b0) begin bad++; $display("FAIL reset_fire got=%0b exp=0", fire1); end
      total++; if (x2 !== 12'd3135) begin bad++; $display("FAIL reset_x2 got=%0d exp=3135", x2); end
      repeat (2) @(negedge clk);
      Reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_move_right();
      apply_reset();
      keycode = {24'h0, K_RT};
      ticks(10);
      total++; if (x1 !== 12'd720) begin bad++; $display("FAIL right_x got=%0d exp=720", x1); end
      total++; if (y1 !== 12'd700) begin bad++; $display("FAIL right_y got=%0d exp=700", y1); end
      total++; if (dir1 !== 2'd2) begin bad++; $display("FAIL right_dir got=%0d exp=2", dir1); end
      total++; if (mov1 !== 1'b1) begin bad++; $display("FAIL right_moving got=%0b exp=1", mov1); end
   endtask

   task automatic test_multi_key();
      apply_reset();
      keycode = {8'h00, K_UP, K_DN, K_LT};
      ticks(1);
      total++; if (x1 !== 12'd698) begin bad++; $display("FAIL multi_x got=%0d exp=698", x1); end
      total++; if (y1 !== 12'd700) begin bad++; $display("FAIL multi_y got=%0d exp=700", y1); end
      total++; if (dir1 !== 2'd3) begin bad++; $display("FAIL multi_dir got=%0d exp=3", dir1); end
      // duplicate slots count as a single press
      keycode = {K_RT, K_RT, 8'h00, 8'h00};
      ticks(1);
      total++; if (x1 !== 12'd700) begin bad++; $display("FAIL dup_x got=%0d exp=700", x1); end
      // no key: position holds, moving drops
      keycode = '0;
      ticks(1);
      total++; if (mov1 !== 1'b0 || dir1 !== 2'd2) begin
         bad++; $display("FAIL idle_hold got=mov%0b/dir%0d exp=mov0/dir2", mov1, dir1); end
   endtask

   task automatic test_left_clamp();
      logic [11:0] exp_x [3];
      logic        exp_m [3];
      exp_x = '{12'd64, 12'd64, 12'd64};
      exp_m = '{1'b1, 1'b0, 1'b0};
      apply_reset();
      keycode = {24'h0, K_LT};
      ticks(317);
      total++; if (x1 !== 12'd66) begin bad++; $display("FAIL lclamp_pre got=%0d exp=66", x1); end
      for (int i = 0; i < 3; i++) begin
         ticks(1);
         total++; if (x1 !== exp_x[i] || mov1 !== exp_m[i]) begin
            bad++; $display("FAIL lclamp_t%0d got=x%0d/m%0b exp=x%0d/m%0b", i, x1, mov1, exp_x[i], exp_m[i]); end
      end
      // one blocked axis still lets the other move
      keycode = {16'h0, K_LT, K_DN};
      ticks(1);
      total++; if (x1 !== 12'd64 || y1 !== 12'd702 || mov1 !== 1'b1) begin
         bad++; $display("FAIL slide got=x%0d/y%0d/m%0b exp=x64/y702/m1", x1, y1, mov1); end
   endtask

   task automatic test_right_clamp();
      apply_reset();
      keycode = {24'h0, K_RT};
      ticks(1);
      total++; if (x2 !== 12'd3136 || mov2 !== 1'b1) begin
         bad++; $display("FAIL rclamp_t1 got=x%0d/m%0b exp=x3136/m1", x2, mov2); end
      ticks(1);
      total++; if (x2 !== 12'd3136 || mov2 !== 1'b0) begin
         bad++; $display("FAIL rclamp_t2 got=x%0d/m%0b exp=x3136/m0", x2, mov2); end
   endtask

   task automatic test_aim();
      apply_reset();
      keycode = {16'h0, K_DN, K_ART};
      ticks(1);
      total++; if (dir1 !== 2'd2 || y1 !== 12'd702) begin
         bad++; $display("FAIL aim_t1 got=dir%0d/y%0d exp=dir2/y702", dir1, y1); end
      ticks(1);
      total++; if (dir1 !== 2'd2 || y1 !== 12'd704 || x1 !== 12'd700) begin
         bad++; $display("FAIL aim_t2 got=dir%0d/y%0d/x%0d exp=dir2/y704/x700", dir1, y1, x1); end
      keycode = '0;
      ticks(1);
      total++; if (dir1 !== 2'd2 || mov1 !== 1'b0 || y1 !== 12'd704) begin
         bad++; $display("FAIL aim_release got=dir%0d/m%0b/y%0d exp=dir2/m0/y704", dir1, mov1, y1); end
   endtask

   task automatic test_fire_repeat();
      logic [9:0] m1, m2;
      logic       wide;
      logic       a, b, c, d;
      m1 = '0; m2 = '0; wide = 1'b0;
      apply_reset();
      keycode = {24'h0, K_FIRE};
      for (int i = 0; i < 10; i++) begin
         do_tick(a, b, c, d);
         m1[i] = a; m2[i] = b;
         wide  = wide | c | d;
      end
      total++; if (m2 !== 10'b01_0001_0001) begin
         bad++; $display("FAIL fire_cd3 got=%b exp=0100010001", m2); end
      total++; if (m1 !== 10'b00_0000_0001) begin
         bad++; $display("FAIL fire_cd30 got=%b exp=0000000001", m1); end
      total++; if (wide !== 1'b0) begin
         bad++; $display("FAIL fire_width got=%0b exp=0", wide); end
   endtask

   task automatic test_reset_midcool();
      logic a, b, c, d;
      logic saw;
      apply_reset();
      keycode = {16'h0, K_RT, K_FIRE};
      ticks(2);   // shot, then one cooldown frame
      total++; if (x1 !== 12'd704 || dir1 !== 2'd2) begin
         bad++; $display("FAIL midcool_pre got=x%0d/dir%0d exp=x704/dir2", x1, dir1); end
      @(posedge clk);
      #2;
      VGA_VS  = 1'b1;
      Reset_n = 1'b0;
      #1;
      total++; if (x1 !== 12'd700 || dir1 !== 2'd0 || mov1 !== 1'b0 || fire2 !== 1'b0 || x2 !== 12'd3135) begin
         bad++; $display("FAIL async_reset got=x%0d/dir%0d/m%0b/f%0b/x2_%0d exp=x700/dir0/m0/f0/x2_3135",
                         x1, dir1, mov1, fire2, x2); end
      #1 Reset_n = 1'b1;
      saw = 1'b0;
      repeat (3) begin
         @(negedge clk);
         saw = saw | fire1 | fire2;
      end
      total++; if (saw !== 1'b0 || x1 !== 12'd700) begin
         bad++; $display("FAIL no_tick_at_release got=f%0b/x%0d exp=f0/x700", saw, x1); end
      VGA_VS = 1'b0;
      @(negedge clk);
      do_tick(a, b, c, d);
      total++; if (a !== 1'b1 || b !== 1'b1 || x1 !== 12'd702) begin
         bad++; $display("FAIL fire_after_reset got=f1%0b/f2%0b/x%0d exp=f1 1/f2 1/x702", a, b, x1); end
   endtask

   initial begin
      Reset_n = 1'b1;
      VGA_VS  = 1'b0;
      keycode = '0;
      test_reset();
      test_move_right();
      test_multi_key();
      test_left_clamp();
      test_right_clamp();
      test_aim();
      test_fire_repeat();
      test_reset_midcool();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
